int_disp_queue: RTL and testbench
=================================

Name: int_disp_queue

Overview:
- In-order dispatch queue at the integer-block end of the rename→dispatch interface; receiving side of the per-slot dispatch-valid vector that rename drives toward the int block.
- Accepts up to IN_WIDTH renamed ops per cycle, compacts sparse valid slots, and buffers them in a circular queue.
- Presents up to OUT_WIDTH oldest entries per cycle to the int issue logic.
- Provides all-or-nothing backpressure to rename and a squash/flush input.

Parameters:
- DEPTH, 16, queue entries; power of two, >= max(IN_WIDTH, OUT_WIDTH).
- IN_WIDTH, 4, enqueue slots per cycle; matches RENAME_WIDTH.
- OUT_WIDTH, 4, dequeue slots per cycle.
- DATA_W, 64, payload bits per op.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_flush  in  1  squash all queued ops.
- i_enq_vld  in  IN_WIDTH  per-slot valid from rename; may be non-contiguous.
- i_enq_data  in  IN_WIDTH x DATA_W  per-slot payload.
- o_can_enq  out  1  queue can take IN_WIDTH ops this cycle.
- o_deq_vld  out  OUT_WIDTH  output valid; contiguous from bit 0.
- o_deq_data  out  OUT_WIDTH x DATA_W  slot i = i-th oldest entry.
- i_deq_num  in  $clog2(OUT_WIDTH+1)  number of head entries consumed this cycle.
- o_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- **State:** head and tail pointers, each $clog2(DEPTH) bits and wrapping mod DEPTH; count register; DEPTH x DATA_W storage.
- **Reset:** rst=1 at a clk edge sets head=tail=count=0.
  - Outputs then read o_deq_vld=0, o_can_enq=1, o_count=0.
  - Storage is not reset.
  - rst takes priority over flush, enq and deq.
- **o_can_enq** = (DEPTH - count >= IN_WIDTH).
  - Combinational from registered count only.
  - Same-cycle dequeue does NOT free space for same-cycle enqueue.
- **Enqueue:** when o_can_enq=1, let nenq = popcount(i_enq_vld).
  - Valid slots are written in ascending slot order to tail, tail+1, … (compaction).
  - tail += nenq.
  - If i_enq_vld!=0 while o_can_enq=0, that is a protocol violation: drop the input, leave state unchanged, fire an assertion.
- **Dequeue:**
  - o_deq_vld[i] = (i < count).
  - o_deq_data[i] = mem[(head+i) mod DEPTH]; entries with o_deq_vld[i]=0 are don't-care.
  - i_deq_num entries retire at the edge: head += i_deq_num.
  - i_deq_num > min(count, OUT_WIDTH) is illegal: assertion, and behaviour is undefined.
- **Simultaneous enq and deq:** count_next = count + nenq - i_deq_num.
  - Enqueued ops are never visible at the output in the same cycle.
  - Latency from enqueue to o_deq_vld is 1 cycle minimum.
- **Flush:** i_flush=1 sets head=tail=count=0 at the next edge.
  - Enqueue and dequeue in the same cycle are discarded.
  - Outputs are empty the following cycle.
- **Wrap-around:** pointer arithmetic is mod DEPTH.
  - Program order is preserved across the index DEPTH-1 → 0 boundary for both write compaction and read.
- **Full / empty:**
  - count==DEPTH means full: o_can_enq=0, all OUT_WIDTH vld bits set.
  - count==0 means empty: o_deq_vld=0.
  - count is the only full/empty indicator; no pointer-equality ambiguity.
- **Assertions:** count <= DEPTH always.

Test Plan:
All scenarios use DEPTH=8, IN_WIDTH=4, OUT_WIDTH=4, DATA_W=8.
1. Reset: hold rst 2 cycles with random enq inputs → o_count=0, o_deq_vld=4'b0000, o_can_enq=1. Release, enq vld=4'b1111 → next cycle o_count=4.
2. Sparse compaction: from empty, i_enq_vld=4'b1010 with slot1=0x11, slot3=0x33 → next cycle o_deq_vld=4'b0011, data0=0x11, data1=0x33, o_count=2.
3. Backpressure:
   - Enq 4 then 1 op → o_count=5, o_can_enq=0.
   - Drive vld=4'b1111 → ignored, o_count stays 5.
   - Deq 1 → next cycle o_count=4, o_can_enq=1.
4. Simultaneous enq/deq:
   - With o_count=4 (0x01..0x04), enq 0x05..0x08 and i_deq_num=2 → o_count=6, data0..3=0x03,0x04,0x05,0x06.
   - Note: o_can_enq was 1 because count=4 gives free=4.
5. Wrap-around: cycle enq 4 / deq 4 for 6 cycles with incrementing data → output sequence strictly incrementing across pointer wrap, no gap or duplicate, o_count never exceeds 8.
6. Flush: with o_count=6, assert i_flush with enq vld=4'b1111 and i_deq_num=3 → next cycle o_count=0, o_deq_vld=0, o_can_enq=1. A subsequent enq of 0xAA appears at data0.

Source files
------------

// File: rtl/int_disp_queue_if.sv
// ---------------------------------------------------------------------------
// int_disp_queue_if
// Bundle of the rename -> int-dispatch-queue -> int-issue signals.
//
// Signals (names as seen from the queue):
//   i_flush     squash every queued op
//   i_enq_vld   per-slot enqueue valid from rename (may be sparse)
//   i_enq_data  per-slot enqueue payload
//   o_can_enq   queue can accept a full IN_WIDTH group this cycle
//   o_deq_vld   output valid, contiguous from bit 0
//   o_deq_data  slot i carries the i-th oldest entry
//   i_deq_num   number of head entries consumed by issue this cycle
//   o_count     current occupancy
//
// Modports:
//   master  rename/issue side (drives the i_* signals)
//   slave   the queue itself (drives the o_* signals)
// ---------------------------------------------------------------------------
interface int_disp_queue_if #(
    parameter int DEPTH     = 16,
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 4,
    parameter int DATA_W    = 64
);
    localparam int DEQ_W = $clog2(OUT_WIDTH + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                               i_flush;
    logic [IN_WIDTH-1:0]                i_enq_vld;
    logic [IN_WIDTH-1:0][DATA_W-1:0]    i_enq_data;
    logic                               o_can_enq;
    logic [OUT_WIDTH-1:0]               o_deq_vld;
    logic [OUT_WIDTH-1:0][DATA_W-1:0]   o_deq_data;
    logic [DEQ_W-1:0]                   i_deq_num;
    logic [CNT_W-1:0]                   o_count;

    modport master (
        output i_flush, i_enq_vld, i_enq_data, i_deq_num,
        input  o_can_enq, o_deq_vld, o_deq_data, o_count
    );

    modport slave (
        input  i_flush, i_enq_vld, i_enq_data, i_deq_num,
        output o_can_enq, o_deq_vld, o_deq_data, o_count
    );
endinterface

// File: rtl/int_disp_queue.sv
// ---------------------------------------------------------------------------
// int_disp_queue
// In-order dispatch queue at the integer-block end of rename->dispatch.
// Accepts up to IN_WIDTH renamed ops per cycle (sparse valid slots are
// compacted into consecutive entries), buffers them in a circular queue and
// presents the OUT_WIDTH oldest entries to int issue.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset (dominates flush/enq/deq)
//   bus   int_disp_queue_if.slave (enqueue, dequeue, backpressure, flush,
//         occupancy)
//
// Occupancy is tracked by an explicit count register, so head==tail is never
// used to tell full from empty. Backpressure is all-or-nothing and looks only
// at the registered count: a same-cycle dequeue never frees room for a
// same-cycle enqueue, which keeps o_can_enq off any combinational path from
// the issue side.
// ---------------------------------------------------------------------------
module int_disp_queue #(
    parameter int DEPTH     = 16,
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 4,
    parameter int DATA_W    = 64
) (
    input  logic               clk,
    input  logic               rst,
    int_disp_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Architectural state.
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Combinational helpers.
    logic                           can_enq_s;
    logic                           enq_fire_s;
    logic [CNT_W-1:0]               nenq_s;
    logic [IN_WIDTH-1:0]            wr_en_s;
    logic [IN_WIDTH-1:0][PTR_W-1:0] wr_addr_s;
    logic [CNT_W-1:0]               deq_lim_s;

    // Free-space check against the registered count only.
    always_comb begin
        can_enq_s  = ((CNT_W'(DEPTH) - count_q) >= CNT_W'(IN_WIDTH));
        // A flush or reset discards whatever rename offers this cycle.
        enq_fire_s = can_enq_s & ~bus.i_flush & ~rst;
    end

    // Write compaction: each valid slot lands at tail plus the number of
    // valid slots below it, so program order survives sparse vectors and the
    // DEPTH-1 -> 0 wrap (pointer add is naturally mod DEPTH).
    always_comb begin
        nenq_s    = '0;
        wr_en_s   = '0;
        wr_addr_s = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            wr_addr_s[i] = tail_q + PTR_W'(nenq_s);
            if (enq_fire_s && bus.i_enq_vld[i]) begin
                wr_en_s[i] = 1'b1;
                nenq_s     = nenq_s + CNT_W'(1);
            end else begin
                wr_en_s[i] = 1'b0;
            end
        end
    end

    // Next-state for pointers and occupancy; flush wins over enq/deq.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(bus.i_deq_num);
            tail_d  = tail_q + PTR_W'(nenq_s);
            count_d = count_q + nenq_s - CNT_W'(bus.i_deq_num);
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; intentionally not reset, validity comes from count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (wr_en_s[i]) begin
                mem_q[wr_addr_s[i]] <= bus.i_enq_data[i];
            end
        end
    end

    // Output view: the OUT_WIDTH oldest entries, valid while below count.
    // Freshly written entries only show up after count_q updates, so the
    // enqueue-to-visible latency is at least one cycle.
    always_comb begin
        bus.o_deq_vld  = '0;
        bus.o_deq_data = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            bus.o_deq_vld[i]  = (CNT_W'(i) < count_q);
            bus.o_deq_data[i] = mem_q[head_q + PTR_W'(i)];
        end
    end

    // Backpressure and occupancy straight from the registered state.
    always_comb begin
        bus.o_can_enq = can_enq_s;
        bus.o_count   = count_q;
    end

    // Largest legal dequeue amount this cycle: min(count, OUT_WIDTH).
    always_comb begin
        if (count_q < CNT_W'(OUT_WIDTH)) begin
            deq_lim_s = count_q;
        end else begin
            deq_lim_s = CNT_W'(OUT_WIDTH);
        end
    end

    // Protocol and invariant checks (ignored by synthesis).
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CNT_W'(DEPTH))
                else $error("int_disp_queue: occupancy %0d exceeds depth", count_q);
            // Offering ops under backpressure is dropped by design; flagged
            // as a warning so a deliberate stall probe does not abort a run.
            assert ((bus.i_enq_vld == '0) || can_enq_s)
                else $warning("int_disp_queue: enqueue offered while o_can_enq=0, input dropped");
            assert (CNT_W'(bus.i_deq_num) <= deq_lim_s)
                else $error("int_disp_queue: i_deq_num %0d above limit %0d",
                            bus.i_deq_num, deq_lim_s);
        end
    end
endmodule

// File: tb/tb_int_disp_queue.sv
// Directed bench for int_disp_queue with DEPTH=8, IN/OUT_WIDTH=4, DATA_W=8.
// Inputs change 1 ns after the rising edge; outputs are checked there too,
// i.e. well away from the next active edge.
module tb_int_disp_queue;
    localparam int DEPTH  = 8;
    localparam int IN_W   = 4;
    localparam int OUT_W  = 4;
    localparam int DW     = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int_disp_queue_if #(.DEPTH(DEPTH), .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DATA_W(DW)) bus ();

    int_disp_queue #(.DEPTH(DEPTH), .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passes = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_flush    = 1'b0;
        bus.i_enq_vld  = 4'b0000;
        bus.i_deq_num  = 3'd0;
        bus.i_enq_data = '0;
    endtask

    task automatic set_enq(input logic [3:0] vld, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        bus.i_enq_vld     = vld;
        bus.i_enq_data[0] = d0;
        bus.i_enq_data[1] = d1;
        bus.i_enq_data[2] = d2;
        bus.i_enq_data[3] = d3;
    endtask

    initial begin
        logic [7:0] nxt;
        logic [7:0] exp_v;

        // ---- 1. reset with garbage on the enqueue side ----
        idle();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            set_enq(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            step();
            check("rst_count", bus.o_count, 4'd0);
            check("rst_vld", bus.o_deq_vld, 4'b0000);
            check("rst_can_enq", bus.o_can_enq, 1'b1);
        end
        rst = 1'b0;
        set_enq(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
        step();
        idle();
        check("post_rst_count", bus.o_count, 4'd4);
        check("post_rst_vld", bus.o_deq_vld, 4'b1111);
        check("post_rst_d0", bus.o_deq_data[0], 8'h01);
        check("post_rst_d3", bus.o_deq_data[3], 8'h04);
        bus.i_deq_num = 3'd4;
        step();
        idle();
        check("drain_count", bus.o_count, 4'd0);
        check("drain_vld", bus.o_deq_vld, 4'b0000);

        // ---- 2. sparse compaction ----
        set_enq(4'b1010, 8'h00, 8'h11, 8'h00, 8'h33);
        step();
        idle();
        check("sparse_vld", bus.o_deq_vld, 4'b0011);
        check("sparse_d0", bus.o_deq_data[0], 8'h11);
        check("sparse_d1", bus.o_deq_data[1], 8'h33);
        check("sparse_count", bus.o_count, 4'd2);
        bus.i_deq_num = 3'd2;
        step();
        idle();
        check("sparse_drain", bus.o_count, 4'd0);

        // ---- 3. backpressure ----
        set_enq(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
        step();
        set_enq(4'b0001, 8'h05, 8'h00, 8'h00, 8'h00);
        step();
        idle();
        check("bp_count5", bus.o_count, 4'd5);
        check("bp_can_enq0", bus.o_can_enq, 1'b0);
        set_enq(4'b1111, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
        step();
        idle();
        check("bp_ignored_count", bus.o_count, 4'd5);
        check("bp_ignored_d0", bus.o_deq_data[0], 8'h01);
        check("bp_ignored_vld", bus.o_deq_vld, 4'b1111);
        bus.i_deq_num = 3'd1;
        step();
        idle();
        check("bp_deq1_count", bus.o_count, 4'd4);
        check("bp_deq1_can_enq", bus.o_can_enq, 1'b1);
        check("bp_deq1_d0", bus.o_deq_data[0], 8'h02);
        check("bp_deq1_d3", bus.o_deq_data[3], 8'h05);
        bus.i_deq_num = 3'd4;
        step();
        idle();
        check("bp_drain", bus.o_count, 4'd0);

        // ---- 4. simultaneous enqueue and dequeue ----
        set_enq(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
        step();
        idle();
        check("sim_pre_count", bus.o_count, 4'd4);
        check("sim_pre_can_enq", bus.o_can_enq, 1'b1);
        set_enq(4'b1111, 8'h05, 8'h06, 8'h07, 8'h08);
        bus.i_deq_num = 3'd2;
        step();
        idle();
        check("sim_count", bus.o_count, 4'd6);
        check("sim_d0", bus.o_deq_data[0], 8'h03);
        check("sim_d1", bus.o_deq_data[1], 8'h04);
        check("sim_d2", bus.o_deq_data[2], 8'h05);
        check("sim_d3", bus.o_deq_data[3], 8'h06);

        // ---- 6. flush beats same-cycle enq and deq ----
        set_enq(4'b1111, 8'hF1, 8'hF2, 8'hF3, 8'hF4);
        bus.i_deq_num = 3'd3;
        bus.i_flush   = 1'b1;
        step();
        idle();
        check("flush_count", bus.o_count, 4'd0);
        check("flush_vld", bus.o_deq_vld, 4'b0000);
        check("flush_can_enq", bus.o_can_enq, 1'b1);
        set_enq(4'b0001, 8'hAA, 8'h00, 8'h00, 8'h00);
        step();
        idle();
        check("post_flush_d0", bus.o_deq_data[0], 8'hAA);
        check("post_flush_vld", bus.o_deq_vld, 4'b0001);
        check("post_flush_count", bus.o_count, 4'd1);
        bus.i_deq_num = 3'd1;
        step();
        idle();

        // ---- 5. wrap-around: streaming 4 in / 4 out ----
        nxt = 8'h40;
        for (int c = 0; c < 6; c++) begin
            set_enq(4'b1111, nxt, nxt + 8'd1, nxt + 8'd2, nxt + 8'd3);
            bus.i_deq_num = (c == 0) ? 3'd0 : 3'd4;
            step();
            idle();
            exp_v = 8'h40 + 8'(4 * c);
            check("wrap_count", bus.o_count, 4'd4);
            check("wrap_vld", bus.o_deq_vld, 4'b1111);
            for (int k = 0; k < OUT_W; k++) begin
                check("wrap_data", bus.o_deq_data[k], exp_v + 8'(k));
            end
            nxt = nxt + 8'd4;
        end
        bus.i_deq_num = 3'd4;
        step();
        idle();
        check("wrap_drain", bus.o_count, 4'd0);

        // ---- full boundary ----
        set_enq(4'b1111, 8'h80, 8'h81, 8'h82, 8'h83);
        step();
        set_enq(4'b1111, 8'h84, 8'h85, 8'h86, 8'h87);
        step();
        idle();
        check("full_count", bus.o_count, 4'd8);
        check("full_can_enq", bus.o_can_enq, 1'b0);
        check("full_vld", bus.o_deq_vld, 4'b1111);
        check("full_d0", bus.o_deq_data[0], 8'h80);
        bus.i_deq_num = 3'd4;
        step();
        check("full_half_d0", bus.o_deq_data[0], 8'h84);
        check("full_half_count", bus.o_count, 4'd4);
        step();
        idle();
        check("full_drain_count", bus.o_count, 4'd0);
        check("full_drain_vld", bus.o_deq_vld, 4'b0000);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
